// File: rtl/coef_lut_arbiter.sv
// Round-robin arbiter sharing one registered-read coefficient LUT among NUM_REQ requesters.
// Define COEF_RELOAD_EN to add the runtime coefficient load port (loads take absolute priority).
module coef_lut_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 3584,
    parameter int LUT_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         lut_address,
    output logic                          lut_rden,
    output logic                          lut_wren,
    output logic [DATA_WIDTH-1:0]         lut_data,
    input  logic [DATA_WIDTH-1:0]         lut_q
`ifdef COEF_RELOAD_EN
    ,
    input  logic                          ld_valid,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          ld_ready
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_D = LUT_LATENCY + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = 32'(base) + off;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return PTR_W'(sum);
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [PTR_W-1:0]      rr_ptr_r;
    logic [PTR_W-1:0]      grant_idx_s;
    logic [PTR_W-1:0]      cand_s;
    logic                  grant_found_s;
    logic                  block_s;
    logic                  rd_hs_s;
    logic [ADDR_WIDTH-1:0] grant_addr_s;
    logic                  tag_valid_r [TAG_D];
    logic [PTR_W-1:0]      tag_idx_r   [TAG_D];
    logic                  tag_oor_r   [TAG_D];

`ifdef COEF_RELOAD_EN
    logic ld_hs_s;
    assign ld_ready = ~rst;
    assign ld_hs_s  = ld_valid & ~rst;
    // A load in the same cycle steals the LUT slot, so no read may be granted.
    assign block_s  = rst | ld_hs_s;
`else
    assign block_s  = rst;
`endif

    // Cyclic search from rr_ptr_r; scanning downward leaves the lowest offset as winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = rr_ptr_r;
        cand_s        = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ptr_add(rr_ptr_r, k);
            if (req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    assign rd_hs_s      = grant_found_s & ~block_s;
    assign grant_addr_s = req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];

    // One-hot grant to the selected requester.
    always_comb begin
        req_ready = '0;
        if (rd_hs_s) begin
            req_ready = onehot(grant_idx_s);
        end else begin
            req_ready = '0;
        end
    end

    // Round-robin pointer moves past each granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (rd_hs_s) begin
            rr_ptr_r <= ptr_add(grant_idx_s, 1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // LUT address/read-enable issue register; out-of-range reads keep rden low.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_address <= '0;
            lut_rden    <= 1'b0;
`ifdef COEF_RELOAD_EN
        end else if (ld_hs_s) begin
            lut_rden    <= 1'b0;
            lut_address <= addr_ok(ld_addr) ? ld_addr : lut_address;
`endif
        end else if (rd_hs_s) begin
            lut_address <= grant_addr_s;
            lut_rden    <= addr_ok(grant_addr_s);
        end else begin
            lut_address <= lut_address;
            lut_rden    <= 1'b0;
        end
    end

`ifdef COEF_RELOAD_EN
    // Write issue register for reloads; loads beyond DEPTH are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_wren <= 1'b0;
            lut_data <= '0;
        end else if (ld_hs_s && addr_ok(ld_addr)) begin
            lut_wren <= 1'b1;
            lut_data <= ld_data;
        end else begin
            lut_wren <= 1'b0;
            lut_data <= lut_data;
        end
    end
`else
    assign lut_wren = 1'b0;
    assign lut_data = '0;
`endif

    // Tag shift register aligns {valid, requester, out-of-range} with lut_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAG_D; k++) begin
                tag_valid_r[k] <= 1'b0;
                tag_idx_r[k]   <= '0;
                tag_oor_r[k]   <= 1'b0;
            end
        end else begin
            tag_valid_r[0] <= rd_hs_s;
            tag_idx_r[0]   <= grant_idx_s;
            tag_oor_r[0]   <= ~addr_ok(grant_addr_s);
            for (int k = 1; k < TAG_D; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_idx_r[k]   <= tag_idx_r[k-1];
                tag_oor_r[k]   <= tag_oor_r[k-1];
            end
        end
    end

    // Response register; data holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tag_valid_r[TAG_D-1]) begin
            rsp_valid <= onehot(tag_idx_r[TAG_D-1]);
            rsp_data  <= tag_oor_r[TAG_D-1] ? '0 : lut_q;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= rsp_data;
        end
    end

endmodule

// File: tb/tb_coef_lut_arbiter.sv
// Directed bench for coef_lut_arbiter; LUT model returns address + 0x1000 one cycle after rden.
module tb_coef_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [47:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [11:0] lut_address;
    logic        lut_rden;
    logic        lut_wren;
    logic [31:0] lut_data;
    logic [31:0] lut_q = 32'h0;
`ifdef COEF_RELOAD_EN
    logic        ld_valid;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
`endif

    logic [11:0] addr_tb [4];
    logic [3:0]  v_tab [16];
    logic [3:0]  r_tab [16];
    int          n_tab;
    int          tests = 0;
    int          fails = 0;

    logic        ov_valid = 1'b0;
    logic [11:0] ov_addr  = 12'h0;
    logic [31:0] ov_data  = 32'h0;

    always #5 clk = ~clk;

    assign req_addr = {addr_tb[3], addr_tb[2], addr_tb[1], addr_tb[0]};

    coef_lut_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .lut_address (lut_address),
        .lut_rden    (lut_rden),
        .lut_wren    (lut_wren),
        .lut_data    (lut_data),
        .lut_q       (lut_q)
`ifdef COEF_RELOAD_EN
        ,
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready)
`endif
    );

    // LUT model: one overridable word for reload writes, otherwise address + 0x1000.
    always @(posedge clk) begin
        if (lut_wren) begin
            ov_valid <= 1'b1;
            ov_addr  <= lut_address;
            ov_data  <= lut_data;
        end
        if (lut_rden) begin
            lut_q <= (ov_valid && ov_addr == lut_address) ? ov_data : ({20'h0, lut_address} + 32'h1000);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_q(input logic [11:0] a);
        return (a < 12'hE00) ? ({20'h0, a} + 32'h1000) : 32'h0;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs the stimulus table; issue is expected 1 cycle and response 3 cycles after each grant.
    task automatic run_tab(input string name);
        logic [3:0]  p;
        logic [11:0] a;
        for (int c = 0; c < n_tab + 3; c++) begin
            req_valid = (c < n_tab) ? v_tab[c] : 4'b0000;
            #1;
            check($sformatf("%s ready c%0d", name, c), 32'(req_ready), (c < n_tab) ? 32'(r_tab[c]) : 32'h0);
            check($sformatf("%s wren c%0d", name, c), 32'(lut_wren), 32'h0);
            if (c >= 1) begin
                p = (c - 1 < n_tab) ? r_tab[c-1] : 4'b0000;
                a = addr_tb[oh_idx(p)];
                check($sformatf("%s rden c%0d", name, c), 32'(lut_rden), 32'((p != 4'b0000) && (a < 12'hE00)));
                if (p != 4'b0000 && a < 12'hE00)
                    check($sformatf("%s addr c%0d", name, c), 32'(lut_address), 32'(a));
            end
            if (c >= 3) begin
                p = r_tab[c-3];
                check($sformatf("%s rsp_valid c%0d", name, c), 32'(rsp_valid), 32'(p));
                if (p != 4'b0000)
                    check($sformatf("%s rsp_data c%0d", name, c), rsp_data, exp_q(addr_tb[oh_idx(p)]));
            end
            cyc();
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b1111;
        addr_tb[0] = 12'h010;
        addr_tb[1] = 12'h201;
        addr_tb[2] = 12'h302;
        addr_tb[3] = 12'h403;
`ifdef COEF_RELOAD_EN
        ld_valid = 1'b0;
        ld_addr  = 12'h0;
        ld_data  = 32'h0;
`endif
        repeat (3) cyc();
        #1;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", rsp_data, 32'h0);
        check("reset lut_address", 32'(lut_address), 32'h0);
        check("reset lut_rden", 32'(lut_rden), 32'h0);
        check("reset lut_wren", 32'(lut_wren), 32'h0);
        check("reset lut_data", lut_data, 32'h0);
        req_valid = 4'b0000;
        rst       = 1'b0;
        repeat (2) cyc();

        // Single request from requester 0.
        n_tab = 1; v_tab[0] = 4'b0001; r_tab[0] = 4'b0001;
        run_tab("single");

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        addr_tb[0] = 12'h100;

        // All four held valid: grants rotate 0,1,2,3,0,1,2,3.
        n_tab = 8;
        for (int i = 0; i < 8; i++) begin
            v_tab[i] = 4'b1111;
            r_tab[i] = 4'b0001 << (i % 4);
        end
        run_tab("all4");

        // Pointer to 2 via requester 1, then 3 before 1, then pointer lands on 2.
        n_tab = 4;
        v_tab[0] = 4'b0010; r_tab[0] = 4'b0010;
        v_tab[1] = 4'b1010; r_tab[1] = 4'b1000;
        v_tab[2] = 4'b0010; r_tab[2] = 4'b0010;
        v_tab[3] = 4'b0110; r_tab[3] = 4'b0100;
        run_tab("rr13");

        // Reset one cycle after two grants: in-flight reads discarded.
        req_valid = 4'b0011; #1;
        check("rst grant0", 32'(req_ready), 32'h1);
        cyc();
        #1;
        check("rst grant1", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0000; rst = 1'b1; #1;
        check("rst ready gated", 32'(req_ready), 32'h0);
        cyc();
        req_valid = 4'b1111; #1;
        check("rst ready held", 32'(req_ready), 32'h0);
        check("rst rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst rsp_data", rsp_data, 32'h0);
        check("rst lut_address", 32'(lut_address), 32'h0);
        check("rst lut_rden", 32'(lut_rden), 32'h0);
        cyc();
        rst = 1'b0; req_valid = 4'b0000; #1;
        check("post rst rsp_valid a", 32'(rsp_valid), 32'h0);
        cyc();
        #1;
        check("post rst rsp_valid b", 32'(rsp_valid), 32'h0);
        cyc();
        req_valid = 4'b1111; #1;
        check("post rst grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        repeat (2) cyc();
        #1;
        check("post rst rsp_valid", 32'(rsp_valid), 32'h1);
        check("post rst rsp_data", rsp_data, 32'h0000_1100);
        cyc();

        // Out-of-range address: granted, no rden, zero data at normal latency.
        addr_tb[2] = 12'hE00;
        n_tab = 1; v_tab[0] = 4'b0100; r_tab[0] = 4'b0100;
        run_tab("oor");

`ifdef COEF_RELOAD_EN
        // Load collides with a read of requester 2; read follows and sees new data.
        addr_tb[2] = 12'h020;
        ld_valid = 1'b1; ld_addr = 12'h020; ld_data = 32'hDEADBEEF;
        req_valid = 4'b0100; #1;
        check("ld ready blocked", 32'(req_ready), 32'h0);
        check("ld_ready", 32'(ld_ready), 32'h1);
        cyc();
        ld_valid = 1'b0; #1;
        check("ld wren", 32'(lut_wren), 32'h1);
        check("ld rden", 32'(lut_rden), 32'h0);
        check("ld address", 32'(lut_address), 32'h020);
        check("ld data", lut_data, 32'hDEADBEEF);
        check("ld then grant", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b0000; #1;
        check("ld read rden", 32'(lut_rden), 32'h1);
        check("ld read wren", 32'(lut_wren), 32'h0);
        repeat (2) cyc();
        #1;
        check("ld read rsp_valid", 32'(rsp_valid), 32'h4);
        check("ld read rsp_data", rsp_data, 32'hDEADBEEF);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coef_lut_arbiter.md
Name: coef_lut_arbiter

Overview:
- Shares one single-port interpolation coefficient LUT (lut1_x class, 32-bit x 3584 words, registered read) among NUM_REQ force-pipeline requesters.
- Round-robin arbitration, one read issued per cycle.
- Tracks every in-flight read by tag and routes the returned coefficient to the originating requester.
- Sits between the RL_LJ evaluate-pairs pipelines and the coefficient memory; optionally sequences runtime coefficient reloads.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, coefficient width.
- ADDR_WIDTH, 12, LUT address width.
- DEPTH, 3584, LUT words. Addresses >= DEPTH are invalid.
- LUT_LATENCY, 1, cycles from lut_address/lut_rden to valid lut_q.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant (combinational from req_valid and state).
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  DATA_WIDTH  coefficient for the requester flagged in rsp_valid.
- lut_address  out  ADDR_WIDTH  to LUT address.
- lut_rden  out  1  to LUT rden.
- lut_wren  out  1  to LUT wren.
- lut_data  out  DATA_WIDTH  to LUT data.
- lut_q  in  DATA_WIDTH  from LUT q.
- ld_valid, ld_addr[ADDR_WIDTH], ld_data[DATA_WIDTH]  in; ld_ready  out  1. Present only with the optional feature.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, lut_address=0, lut_rden=0, lut_wren=0, lut_data=0, rr_ptr=0. The tag pipeline is cleared.
- Arbitration:
  - Grant the lowest index i >= rr_ptr (cyclic) with req_valid[i]=1. At most one req_ready bit is set per cycle.
  - On a handshake with requester g, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
  - A requester whose req_valid is held high is granted within NUM_REQ cycles (no starvation among readers).
- Issue stage, for a handshake in cycle t:
  - Cycle t+1: lut_address=addr, lut_rden=1, lut_wren=0.
  - Without a handshake, lut_rden=0 and lut_address holds its last value.
- Tag pipeline:
  - Shift register of depth LUT_LATENCY+1 holding {valid, grant index}.
  - Cycle t+2+LUT_LATENCY: rsp_valid[g]=1 for exactly one cycle, and rsp_data is registered from lut_q.
  - Total latency is 3 cycles at the default. Throughput is 1 read/cycle. Responses return in issue order.
- rsp_data holds its last value when rsp_valid=0.
- Out-of-range address (>= DEPTH):
  - Granted normally, but lut_rden is held 0 for that issue.
  - The response is still returned at the normal latency, with rsp_data=0.
- Requests are not retracted: req_addr must be stable while req_valid=1 and req_ready=0.
- Reset mid-operation: all in-flight reads are discarded and no rsp_valid follows. Arbitration restarts at requester 0 in the first cycle after rst deasserts.

Optional Feature:
- Macro: COEF_RELOAD_EN.
- With the macro defined:
  - Load port present. ld_ready = ~rst.
  - A load handshake in cycle t forces req_ready=0 in cycle t, and rr_ptr holds.
  - Cycle t+1: lut_wren=1, lut_rden=0, lut_address=ld_addr, lut_data=ld_data.
  - Loads have absolute priority and may starve readers. A load to an address >= DEPTH is dropped (lut_wren stays 0).
  - Reads issued before the write return old data. Reads issued after it return new data.
- Without the macro: load port absent; lut_wren=0 and lut_data=0 constantly.

Test Plan (NUM_REQ=4, LUT_LATENCY=1; the LUT model returns q = address + 0x1000 one cycle after rden):
- Single request: req_valid=0001, addr0=0x010 at cycle 5 -> req_ready[0]=1 at 5; lut_rden=1 with address 0x010 at 6; rsp_valid=0001 with rsp_data=0x1010 at 8.
- All four requesters held valid from cycle 10 -> grants in order 0,1,2,3,0,...; one response per cycle from cycle 13; each rsp_data matches its own address.
- Requesters 1 and 3 valid with rr_ptr=2 -> 3 is granted first, then 1; rr_ptr ends at 2.
- Request with addr=0xE00 (3584) -> granted, lut_rden=0 at issue, rsp_valid at +3 with rsp_data=0.
- rst asserted one cycle after two grants -> no rsp_valid afterwards; all outputs 0; the next grant goes to requester 0.
- COEF_RELOAD_EN defined: ld_valid with addr=0x020, data=0xDEADBEEF at the same time as req_valid[2] -> req_ready=0 in that cycle; lut_wren=1 next cycle; requester 2 is granted in the following cycle and a subsequent read of 0x020 returns 0xDEADBEEF.
